sprite_blitter: RTL and testbench

Parametrised sprite-to-framebuffer copy engine. On `start`, it reads a `SPR_W`×`SPR_H` sprite from image memory and writes it into the frame buffer at pixel position (x, y). It supports horizontal and vertical flip, a transparency colour key, right/bottom edge clipping, and image memory with configurable read latency. It sits between the game-logic sequencer, which issues draw commands, and the frame-buffer write port.

---
 rtl/video_pkg.sv | 20 ++
 rtl/blit_delay.sv | 42 ++++
 rtl/sprite_blitter.sv | 153 +++++++++++++++
 tb/tb_sprite_blitter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video definitions: frame geometry defaults, pixel format, colour key
// and the blitter state encoding.
package video_pkg;

   localparam int unsigned FRAME_W_DEF = 320;
   localparam int unsigned FRAME_H_DEF = 240;
   localparam int unsigned PIX_W_DEF   = 24;
   localparam logic [PIX_W_DEF-1:0] TRANSP_KEY_DEF = 24'hFF00FF;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN
   } blit_state_t;

   function automatic int unsigned frame_addr_w(input int unsigned w, input int unsigned h);
      return $clog2(w * h);
   endfunction

endpackage

// File: rtl/blit_delay.sv
// Fixed-depth shift register carrying the write sideband alongside the
// image-memory read latency.
module blit_delay #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned AW    = 17
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          valid_i,
   input  logic          inb_i,
   input  logic [AW-1:0] addr_i,
   output logic          valid_o,
   output logic          inb_o,
   output logic [AW-1:0] addr_o
);

   logic [DEPTH-1:0]         valid_q;
   logic [DEPTH-1:0]         inb_q;
   logic [DEPTH-1:0][AW-1:0] addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         inb_q   <= '0;
         addr_q  <= '0;
      end else begin
         valid_q[0] <= valid_i;
         inb_q[0]   <= inb_i;
         addr_q[0]  <= addr_i;
         for (int unsigned i = DEPTH - 1; i > 0; i--) begin
            valid_q[i] <= valid_q[i-1];
            inb_q[i]   <= inb_q[i-1];
            addr_q[i]  <= addr_q[i-1];
         end
      end
   end

   assign valid_o = valid_q[DEPTH-1];
   assign inb_o   = inb_q[DEPTH-1];
   assign addr_o  = addr_q[DEPTH-1];

endmodule

// File: rtl/sprite_blitter.sv
// Sprite-to-framebuffer copy engine: one image read per clock, flip on the
// source side, clip and colour-key on the frame-buffer write side.
module sprite_blitter
   import video_pkg::*;
#(
   parameter int unsigned FRAME_W = FRAME_W_DEF,
   parameter int unsigned FRAME_H = FRAME_H_DEF,
   parameter int unsigned SPR_W   = 8,
   parameter int unsigned SPR_H   = 8,
   parameter int unsigned IDX_W   = 8,
   parameter int unsigned PIX_W   = PIX_W_DEF,
   parameter int unsigned MEM_LAT = 1,
   parameter logic [PIX_W-1:0] TRANSP_KEY = TRANSP_KEY_DEF,
   localparam int unsigned XW  = $clog2(FRAME_W),
   localparam int unsigned YW  = $clog2(FRAME_H),
   localparam int unsigned CW  = $clog2(SPR_W),
   localparam int unsigned RW  = $clog2(SPR_H),
   localparam int unsigned NW  = CW + RW,
   localparam int unsigned FAW = frame_addr_w(FRAME_W, FRAME_H)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [XW-1:0]       x_in,
   input  logic [YW-1:0]       y_in,
   input  logic [IDX_W-1:0]    idx_in,
   input  logic                flip_h,
   input  logic                flip_v,
   output logic [IDX_W+NW-1:0] img_mem_addr,
   input  logic [PIX_W-1:0]    img_pixel_data,
   output logic [FAW-1:0]      frame_addr,
   output logic [PIX_W-1:0]    frame_data,
   output logic                frame_we,
   output logic                rdy,
   output logic                done
);

   localparam int unsigned DW  = $clog2(MEM_LAT + 1);
   localparam int unsigned XSW = XW + 1;
   localparam int unsigned YSW = YW + 1;

   blit_state_t state_q, state_d;
   logic [NW-1:0]    cnt_q, cnt_d;
   logic [DW-1:0]    dcnt_q, dcnt_d;
   logic [XW-1:0]    x_q;
   logic [YW-1:0]    y_q;
   logic [IDX_W-1:0] idx_q;
   logic             fh_q, fv_q;
   logic             accept, issue;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dcnt_d  = dcnt_q;
      accept  = 1'b0;
      issue   = 1'b0;
      rdy     = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            rdy = 1'b1;
            if (start) begin
               accept  = 1'b1;
               cnt_d   = '0;
               state_d = READ;
            end
         end
         READ: begin
            issue = 1'b1;
            cnt_d = cnt_q + NW'(1);
            if (cnt_q == NW'(SPR_W * SPR_H - 1)) begin
               dcnt_d  = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            dcnt_d = dcnt_q + DW'(1);
            if (dcnt_q == DW'(MEM_LAT - 1)) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dcnt_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         idx_q   <= '0;
         fh_q    <= 1'b0;
         fv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dcnt_q  <= dcnt_d;
         if (accept) begin
            x_q   <= x_in;
            y_q   <= y_in;
            idx_q <= idx_in;
            fh_q  <= flip_h;
            fv_q  <= flip_v;
         end
      end
   end

   // Sprite dimensions are powers of two, so DIM-1-n is just the bitwise complement.
   logic [CW-1:0] col, src_col;
   logic [RW-1:0] row, src_row;

   assign col     = cnt_q[CW-1:0];
   assign row     = cnt_q[NW-1:CW];
   assign src_col = fh_q ? ~col : col;
   assign src_row = fv_q ? ~row : row;

   assign img_mem_addr = issue ? {idx_q, src_row, src_col} : '0;

   logic [XSW-1:0] xs;
   logic [YSW-1:0] ys;
   logic           inb;
   logic [FAW-1:0] dest;

   assign xs   = {1'b0, x_q} + XSW'(col);
   assign ys   = {1'b0, y_q} + YSW'(row);
   assign inb  = (xs < XSW'(FRAME_W)) && (ys < YSW'(FRAME_H));
   assign dest = FAW'(ys) * FAW'(FRAME_W) + FAW'(xs);

   logic           pv, pinb;
   logic [FAW-1:0] paddr;

   blit_delay #(
      .DEPTH (MEM_LAT),
      .AW    (FAW)
   ) u_delay (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (issue),
      .inb_i   (inb),
      .addr_i  (dest),
      .valid_o (pv),
      .inb_o   (pinb),
      .addr_o  (paddr)
   );

   assign frame_we   = pv && pinb && (img_pixel_data != TRANSP_KEY);
   assign frame_data = pv ? img_pixel_data : '0;
   assign frame_addr = paddr;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: MEM_LAT=1 and MEM_LAT=3 instances share stimulus.
module tb_sprite_blitter;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic       start = 1'b0;
   logic [8:0] x_in = '0;
   logic [7:0] y_in = '0;
   logic [7:0] idx_in = '0;
   logic       flip_h = 1'b0, flip_v = 1'b0;
   logic       trans = 1'b0;

   logic [13:0] ma1, ma3;
   logic [23:0] md1, md3;
   logic [16:0] fa1, fa3;
   logic [23:0] fd1, fd3;
   logic        fwe1, fwe3, rdy1, rdy3, dn1, dn3;

   sprite_blitter dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .y_in(y_in),
      .idx_in(idx_in), .flip_h(flip_h), .flip_v(flip_v), .img_mem_addr(ma1),
      .img_pixel_data(md1), .frame_addr(fa1), .frame_data(fd1), .frame_we(fwe1),
      .rdy(rdy1), .done(dn1)
   );

   sprite_blitter #(.MEM_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .y_in(y_in),
      .idx_in(idx_in), .flip_h(flip_h), .flip_v(flip_v), .img_mem_addr(ma3),
      .img_pixel_data(md3), .frame_addr(fa3), .frame_data(fd3), .frame_we(fwe3),
      .rdy(rdy3), .done(dn3)
   );

   // Image memory: data is the zero-extended address, or the key on even addresses.
   function automatic logic [23:0] memf(input logic [13:0] a);
      if (trans && !a[0]) return 24'hFF00FF;
      return {10'd0, a};
   endfunction

   logic [13:0] a3p1, a3p2;
   always @(posedge clk) begin
      md1  <= memf(ma1);
      a3p1 <= ma3;
      a3p2 <= a3p1;
      md3  <= memf(a3p2);
   end

   int cyc = 0, base = 0, rel = 0;
   logic clr = 1'b0;
   always @(posedge clk) cyc <= cyc + 1;

   int cur_x = 0, cur_y = 0, cur_idx = 0;
   logic cur_fh = 1'b0, cur_fv = 1'b0;

   int nwr[2], fwc[2], fwa[2], lwa[2], mxa[2], dcyc[2], dcnt[2], rcyc[2];
   int mis[2], evc[2], d6410[2], rd1[2];

   task automatic observe(input int i, input logic we, input logic [16:0] a,
                          input logic [23:0] d, input logic dn_, input logic rd_);
      int sc, sr, col, row, ex;
      if (we) begin
         nwr[i]++;
         if (nwr[i] == 1) begin
            fwc[i] = rel;
            fwa[i] = int'(a);
         end
         lwa[i] = int'(a);
         if (int'(a) > mxa[i]) mxa[i] = int'(a);
         if (int'(a) == 6410) d6410[i] = int'(d);
         sc  = int'(d[2:0]);
         sr  = int'(d[5:3]);
         col = cur_fh ? 7 - sc : sc;
         row = cur_fv ? 7 - sr : sr;
         ex  = (cur_y + row) * 320 + cur_x + col;
         if (ex != int'(a) || int'(d[23:6]) != cur_idx) mis[i]++;
         if (((int'(a) % 320) % 2) == 0) evc[i]++;
      end
      if (dn_) begin
         dcnt[i]++;
         dcyc[i] = rel;
      end
      if (rd_ && dcnt[i] > 0 && rcyc[i] < 0) rcyc[i] = rel;
   endtask

   always @(negedge clk) begin
      rel = cyc - base;
      if (clr) begin
         for (int i = 0; i < 2; i++) begin
            nwr[i] = 0; fwc[i] = -1; fwa[i] = -1; lwa[i] = -1; mxa[i] = -1;
            dcyc[i] = -1; dcnt[i] = 0; rcyc[i] = -1; mis[i] = 0; evc[i] = 0;
            d6410[i] = -1; rd1[i] = -1;
         end
      end
      if (rel == 1) begin
         rd1[0] = int'(ma1);
         rd1[1] = int'(ma3);
      end
      observe(0, fwe1, fa1, fd1, dn1, rdy1);
      observe(1, fwe3, fa3, fd3, dn3, rdy3);
   end

   int total = 0, failed = 0;

   task automatic check(input string tag, input longint obs, input longint expv);
      total++;
      assert (obs === expv) else begin
         failed++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
      end
   endtask

   task automatic issue(input int x, input int y, input int idx, input logic fh, input logic fv);
      @(posedge clk); #1;
      cur_x = x; cur_y = y; cur_idx = idx; cur_fh = fh; cur_fv = fv;
      x_in = 9'(x); y_in = 8'(y); idx_in = 8'(idx); flip_h = fh; flip_v = fv;
      start = 1'b1; base = cyc; clr = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; clr = 1'b0;
   endtask

   task automatic wait_done(input int n0, input int n1);
      int ok;
      ok = 0;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk); #1;
         if (dcnt[0] >= n0 && dcnt[1] >= n1 && rdy1 && rdy3) begin
            ok = 1;
            break;
         end
      end
      check("completion_timeout", ok, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset values
      #2 rst_n = 1'b0;
      #1;
      check("rst_rdy", rdy1, 1);
      check("rst_done", dn1, 0);
      check("rst_we", fwe1, 0);
      check("rst_img_addr", ma1, 0);
      check("rst_frame_addr", fa1, 0);
      check("rst_frame_data", fd1, 0);
      check("rst_rdy_lat3", rdy3, 1);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Basic draw
      issue(10, 20, 3, 1'b0, 1'b0);
      wait_done(1, 1);
      check("basic_nwr", nwr[0], 64);
      check("basic_first_rd", rd1[0], 192);
      check("basic_first_wr_cyc", fwc[0], 2);
      check("basic_first_wr_addr", fwa[0], 6410);
      check("basic_last_wr_addr", lwa[0], 8657);
      check("basic_done_cyc", dcyc[0], 65);
      check("basic_done_cnt", dcnt[0], 1);
      check("basic_rdy_cyc", rcyc[0], 66);
      check("basic_align", mis[0], 0);
      check("lat3_nwr", nwr[1], 64);
      check("lat3_first_wr_cyc", fwc[1], 4);
      check("lat3_last_wr_addr", lwa[1], 8657);
      check("lat3_done_cyc", dcyc[1], 67);
      check("lat3_rdy_cyc", rcyc[1], 68);
      check("lat3_align", mis[1], 0);

      // Horizontal flip
      issue(10, 20, 3, 1'b1, 1'b0);
      wait_done(1, 1);
      check("fliph_first_rd", rd1[0], 199);
      check("fliph_data_6410", d6410[0], 199);
      check("fliph_nwr", nwr[0], 64);
      check("fliph_align", mis[0], 0);
      check("fliph_lat3_data_6410", d6410[1], 199);

      // Vertical flip
      issue(10, 20, 3, 1'b0, 1'b1);
      wait_done(1, 1);
      check("flipv_first_rd", rd1[0], 248);
      check("flipv_align", mis[0], 0);
      check("flipv_lat3_align", mis[1], 0);

      // Right/bottom clipping
      issue(316, 236, 1, 1'b0, 1'b0);
      wait_done(1, 1);
      check("clip_nwr", nwr[0], 16);
      check("clip_max_addr", mxa[0], 76799);
      check("clip_done_cyc", dcyc[0], 65);
      check("clip_align", mis[0], 0);
      check("clip_lat3_nwr", nwr[1], 16);
      check("clip_lat3_done_cyc", dcyc[1], 67);

      // Fully off-screen sprite still runs to completion with no writes
      issue(400, 250, 2, 1'b0, 1'b0);
      wait_done(1, 1);
      check("offscreen_nwr", nwr[0], 0);
      check("offscreen_done_cyc", dcyc[0], 65);

      // Transparency key
      trans = 1'b1;
      issue(10, 20, 3, 1'b0, 1'b0);
      wait_done(1, 1);
      trans = 1'b0;
      check("transp_nwr", nwr[0], 32);
      check("transp_even_cols", evc[0], 0);
      check("transp_align", mis[0], 0);
      check("transp_lat3_nwr", nwr[1], 32);

      // Back-to-back: restart in the first rdy cycle (MEM_LAT=3 is still draining and ignores it)
      issue(10, 20, 3, 1'b0, 1'b0);
      for (int k = 0; k < 200; k++) begin
         if (dcnt[0] >= 1) break;
         @(posedge clk); #1;
      end
      check("b2b_rdy_at_restart", rdy1, 1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(2, 1);
      check("b2b_nwr", nwr[0], 128);
      check("b2b_done_cnt", dcnt[0], 2);
      check("b2b_second_done_cyc", dcyc[0], 131);
      check("b2b_align", mis[0], 0);
      check("b2b_lat3_nwr", nwr[1], 64);
      check("b2b_lat3_done_cnt", dcnt[1], 1);

      // Start while busy is ignored; reset mid-operation aborts
      issue(10, 20, 3, 1'b0, 1'b0);
      repeat (9) begin
         @(posedge clk); #1;
      end
      x_in = 9'd100;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("rstmid_we", fwe1, 0);
      check("rstmid_rdy", rdy1, 1);
      check("rstmid_done", dn1, 0);
      check("rstmid_lat3_we", fwe3, 0);
      check("rstmid_lat3_rdy", rdy3, 1);
      repeat (3) @(posedge clk);
      #1;
      check("rstmid_nwr", nwr[0], 28);
      check("rstmid_lat3_nwr", nwr[1], 26);
      check("rstmid_align", mis[0], 0);
      check("rstmid_done_cnt", dcnt[0], 0);
      check("rstmid_lat3_done_cnt", dcnt[1], 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("post_rst_rdy", rdy1, 1);

      $display("%0d/%0d checks passed", total - failed, total);
      $finish;
   end

endmodule
